fpu_f32_div_arbiter: RTL

Shares one `FPU_F32_DIV` instance among `PORT_COUNT` requesters with round-robin arbitration and valid/ready handshakes on both request and response sides. The divider is a multicycle combinational path. This block holds its operands stable for `DIV_CYCLES` cycles, then registers the quotient into the issuing port's one-entry response buffer. It sits between the shader/ALU issue ports and the single shared divider instance.

---
 rtl/fpu_f32_div_arbiter.sv | 160 ++++++++++++++++
 1 files changed

// File: rtl/fpu_f32_div_arbiter.sv
// Round-robin arbiter sharing one multicycle FP32 divider among PORT_COUNT requesters.
// Operands are held for DIV_CYCLES cycles, then the quotient lands in the issuing port's response slot.
module fpu_f32_div_arbiter #(
    parameter int PORT_COUNT = 4,
    parameter int DIV_CYCLES = 4
) (
    input  logic                     CLK,
    input  logic                     nRST,
    input  logic [PORT_COUNT-1:0]    REQ_VALID,
    output logic [PORT_COUNT-1:0]    REQ_READY,
    input  logic [PORT_COUNT*32-1:0] REQ_A,
    input  logic [PORT_COUNT*32-1:0] REQ_B,
    output logic [PORT_COUNT-1:0]    RSP_VALID,
    input  logic [PORT_COUNT-1:0]    RSP_READY,
    output logic [PORT_COUNT*32-1:0] RSP_DATA,
    output logic [31:0]              DIV_A,
    output logic [31:0]              DIV_B,
    input  logic [31:0]              DIV_O,
    output logic                     BUSY
);

    localparam int IDX_W = $clog2(PORT_COUNT);
    localparam int CNT_W = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(DIV_CYCLES - 1);
    localparam logic [IDX_W-1:0] LAST_RST = IDX_W'(PORT_COUNT - 1);

    typedef enum logic {
        IDLE = 1'b0,
        EXEC = 1'b1
    } state_t;

    state_t                state, state_nxt;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic [IDX_W-1:0]      last, cur;
    logic [IDX_W-1:0]      scan_idx;
    logic [IDX_W-1:0]      grant_idx;
    logic                  grant_any;
    logic [PORT_COUNT-1:0] elig, pop, grant_oh, cap_oh;
    logic                  accept, capture;

    logic [31:0]           opa_p0, opb_p0;
    logic [PORT_COUNT-1:0] rsp_vld_p1;
    logic [31:0]           rsp_data_p1 [PORT_COUNT];

    // Eligibility uses only the registered response flag, so RSP_READY never reaches REQ_READY.
    assign elig = REQ_VALID & ~rsp_vld_p1;
    assign pop  = rsp_vld_p1 & RSP_READY;

    always_comb begin : rr_scan
        grant_any = 1'b0;
        grant_idx = '0;
        scan_idx  = '0;
        for (int k = 1; k <= PORT_COUNT; k++) begin
            scan_idx = IDX_W'((int'(last) + k) % PORT_COUNT);
            if (!grant_any && elig[scan_idx]) begin
                grant_any = 1'b1;
                grant_idx = scan_idx;
            end
        end
    end

    always_comb begin : grant_gen
        grant_oh = '0;
        if (nRST && (state == IDLE) && grant_any) begin
            grant_oh[grant_idx] = 1'b1;
        end
    end

    assign REQ_READY = grant_oh;
    assign accept    = |(REQ_VALID & grant_oh);
    assign capture   = (state == EXEC) && (cnt == '0);

    always_comb begin : cap_gen
        cap_oh = '0;
        if (capture) begin
            cap_oh[cur] = 1'b1;
        end
    end

    always_comb begin : fsm_next
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            IDLE: begin
                if (accept) begin
                    state_nxt = EXEC;
                    cnt_nxt   = CNT_LOAD;
                end
            end
            EXEC: begin
                if (cnt == '0) begin
                    state_nxt = IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin : fsm_reg
        if (!nRST) begin
            state <= IDLE;
            cnt   <= '0;
            last  <= LAST_RST;
            cur   <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            if (accept) begin
                last <= grant_idx;
                cur  <= grant_idx;
            end
        end
    end

    // Stage p0: granted operands latched and held on the divider inputs through EXEC.
    always_ff @(posedge CLK) begin : opnd_reg
        if (!nRST) begin
            opa_p0 <= '0;
            opb_p0 <= '0;
        end else if (accept) begin
            opa_p0 <= REQ_A[{grant_idx, 5'd0} +: 32];
            opb_p0 <= REQ_B[{grant_idx, 5'd0} +: 32];
        end
    end

    // Stage p1: quotient captured into the issuing port's one-entry response buffer.
    always_ff @(posedge CLK) begin : rsp_vld_reg
        if (!nRST) begin
            rsp_vld_p1 <= '0;
        end else begin
            rsp_vld_p1 <= (rsp_vld_p1 & ~pop) | cap_oh;
        end
    end

    always_ff @(posedge CLK) begin : rsp_data_reg
        for (int i = 0; i < PORT_COUNT; i++) begin
            if (!nRST) begin
                rsp_data_p1[i] <= '0;
            end else if (cap_oh[i]) begin
                rsp_data_p1[i] <= DIV_O;
            end
        end
    end

    for (genvar gi = 0; gi < PORT_COUNT; gi++) begin : g_rsp_pack
        assign RSP_DATA[gi*32 +: 32] = rsp_data_p1[gi];
    end

    assign RSP_VALID = rsp_vld_p1;
    assign DIV_A     = opa_p0;
    assign DIV_B     = opb_p0;
    assign BUSY      = (state == EXEC);

    a_ready_onehot0: assert property (@(posedge CLK) disable iff (!nRST) $onehot0(REQ_READY));
    a_no_grant_exec: assert property (@(posedge CLK) disable iff (!nRST) (state == EXEC) |-> (REQ_READY == '0));
    a_grant_eligible: assert property (@(posedge CLK) disable iff (!nRST) ((REQ_READY & ~elig) == '0));

endmodule
